uc_multiciclo: RTL
==================

Name: uc_multiciclo

Overview:
- Multicycle main control FSM for the RISC-V datapath.
- Sequences one instruction over 3–5 cycles, sharing one ALU and one unified instruction/data memory port. Replaces the single-cycle combinational control unit.
- Decodes op/f3/f7/zero from the datapath and drives every mux select, write enable and ALU control.
- Waits on a memory-ready handshake and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_WAIT_MAX, 15, max cycles a memory state waits for memReady before trapping (0 = wait forever).
- ERR_STICKY, 1, 1: ERROR held until rst; 0: ERROR returns to FETCH after one cycle.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- op  in  7  instr[6:0] from instruction register
- f3  in  3  instr[14:12]
- f7  in  7  instr[31:25]; only bit 5 used
- zero  in  1  ALU zero flag
- memReady  in  1  memory completed current access this cycle
- pcWrite  out  1  PC register load enable
- adrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  instruction register (and oldPC) load enable
- regWrite  out  1  register bank write enable
- resultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- aluSrcA  out  2  00 PC, 01 oldPC, 10 rd1
- aluSrcB  out  2  00 rd2, 01 immExt, 10 constant 4
- immSrc  out  2  00 I, 01 S, 10 B, 11 J
- aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  high while in ERROR
- stateDbg  out  4  current state encoding

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, ERROR=11.
- Reset:
  - rst sampled high → state FETCH and wait counter 0 at the edge.
  - While rst is high, pcWrite, memRead, memWrite, irWrite, regWrite and illegal are forced 0.
  - Select outputs take FETCH values.
  - Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- Outputs are Moore-decoded from state, except:
  - immSrc: decoded from op.
  - aluControl in ALU-op states: decoded from f3/f7.
  - The memReady-gated and zero-gated enables listed below.
- FETCH:
  - memRead=1, adrSrc=0, aluSrcA=00, aluSrcB=10, add, resultSrc=10.
  - irWrite=pcWrite=memReady.
  - Stays until memReady=1, then DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, add (branch target precompute). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - other → ERROR
- MEMADR: aluSrcA=10, aluSrcB=01, add. Next MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: memRead=1, adrSrc=1. Holds until memReady, then MEMWB.
- MEMWB: resultSrc=01, regWrite=1 → FETCH.
- MEMWRITE: memWrite=1, adrSrc=1. Holds until memReady, then FETCH.
  - memWrite stays high for every waiting cycle; memory must tolerate a held request.
- EXECR: aluSrcA=10, aluSrcB=00, funct ALU decode → ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, funct ALU decode → ALUWB.
- ALUWB: resultSrc=00, regWrite=1 → FETCH.
- JAL: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1 → ALUWB (rd = oldPC+4).
- BEQ: aluSrcA=10, aluSrcB=00, sub, resultSrc=00, pcWrite=zero → FETCH.
- Funct ALU decode by f3:
  - 000: sub if {op[5],f7[5]}=11, else add
  - 010: slt
  - 110: or
  - 111: and
  - other f3 → next state ERROR instead of ALUWB
- Wait counter:
  - Counts cycles in FETCH/MEMREAD/MEMWRITE with memReady=0; cleared on any state change.
  - Reaching MEM_WAIT_MAX with memReady still 0 → ERROR, no enables asserted that cycle.
  - memReady=1 on the same cycle the limit is reached: memReady wins.
- ERROR: illegal=1, all enables 0. Stays until rst if ERR_STICKY=1, else → FETCH.
- memReady outside memory states is ignored.

Optional Feature:
- Macro UC_MC_INSTRET_EN.
- When defined:
  - Extra output instret [31:0] counts completed instructions: increments on the cycle leaving MEMWB, MEMWRITE (memReady=1), ALUWB or BEQ.
  - Reset to 0 by rst; wraps from 0xFFFFFFFF to 0.
- When undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package uc_pkg: state encoding, opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL), aluControl codes, resultSrc/aluSrcA/aluSrcB/immSrc encodings.
- Sub-module alu_dec: combinational aluOp(2)/f3/op5/f7b5 → aluControl plus funct-illegal flag. Reused by the single-cycle control unit.

Test Plan:
- add x3,x1,x2 (0x002081B3), memReady=1 always → states 0,1,6,7,0; regWrite only in ALUWB; aluControl=000 in EXECR.
- lw (0x0000A183), memReady low 3 cycles in MEMREAD → MEMREAD held 4 cycles with memRead=1; regWrite=1 exactly once in MEMWB.
- beq with zero=1, then zero=0 → pcWrite=1 in BEQ only when zero=1; BEQ → FETCH both cases.
- Opcode 0x7F in DECODE → ERROR next cycle, illegal=1 persists 10 cycles; rst=1 → FETCH, illegal=0 after edge.
- FETCH with memReady=0 for 15 cycles (MEM_WAIT_MAX=15) → ERROR; repeat with memReady=1 on cycle 15 → DECODE.
- rst asserted during MEMWRITE with memReady=0 → memWrite=0 that cycle, FETCH next; with UC_MC_INSTRET_EN, instret=0 after reset and =3 after add, lw, sw.

Source files
------------

// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared encodings for the multicycle control unit
package uc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src_of = IMM_S;
            OP_BEQ:  imm_src_of = IMM_B;
            OP_JAL:  imm_src_of = IMM_J;
            default: imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - ALU control decoder shared with the single-cycle control unit
module alu_dec
    import uc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] f3,
    input  logic       op5,
    input  logic       f7b5,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (f3)
                    3'b000:  alu_control = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multicycle RISC-V main control FSM
// Optional retired-instruction counter port enabled by UC_MC_INSTRET_EN.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int ERR_STICKY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic        zero,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        adrSrc,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        regWrite,
    output logic [1:0]  resultSrc,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  immSrc,
    output logic [2:0]  aluControl,
    output logic        illegal,
`ifdef UC_MC_INSTRET_EN
    output logic [31:0] instret,
`endif
    output logic [3:0]  stateDbg
);

    localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t          state, state_next;
    logic [CW-1:0]   wait_cnt;
    logic [1:0]      alu_op;
    logic            funct_illegal;
    logic            mem_state;
    logic            timeout;
    logic            unused_f7;

    assign unused_f7 = ^{f7[6], f7[4:0]};

    alu_dec u_alu_dec (
        .alu_op        (alu_op),
        .f3            (f3),
        .op5           (op[5]),
        .f7b5          (f7[5]),
        .alu_control   (aluControl),
        .funct_illegal (funct_illegal)
    );

    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    // memReady on the limit cycle still completes the access
    assign timeout   = (MEM_WAIT_MAX != 0) && mem_state && !memReady
                       && ((int'(wait_cnt) + 1) >= MEM_WAIT_MAX);
    assign immSrc    = imm_src_of(op);
    assign stateDbg  = state;

    always_comb begin
        state_next = state;
        pcWrite    = 1'b0;
        adrSrc     = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        illegal    = 1'b0;
        resultSrc  = RES_ALUOUT;
        aluSrcA    = SRCA_PC;
        aluSrcB    = SRCB_RD2;
        alu_op     = ALUOP_ADD;

        case (state)
            S_FETCH: begin
                memRead   = !timeout;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALURESULT;
                if (timeout) begin
                    state_next = S_ERROR;
                end else if (memReady) begin
                    irWrite    = 1'b1;
                    pcWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default:      state_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                aluSrcA    = SRCA_RD1;
                aluSrcB    = SRCB_IMM;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc  = 1'b1;
                memRead = !timeout;
                if (timeout)       state_next = S_ERROR;
                else if (memReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc  = RES_DATA;
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = !timeout;
                if (timeout)       state_next = S_ERROR;
                else if (memReady) state_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                aluSrcA    = SRCA_RD1;
                aluSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                state_next = funct_illegal ? S_ERROR : S_ALUWB;
            end
            S_ALUWB: begin
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                aluSrcA    = SRCA_OLDPC;
                aluSrcB    = SRCB_FOUR;
                pcWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_BEQ: begin
                aluSrcA    = SRCA_RD1;
                aluSrcB    = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                pcWrite    = zero;
                state_next = S_FETCH;
            end
            S_ERROR: begin
                illegal    = 1'b1;
                state_next = (ERR_STICKY != 0) ? S_ERROR : S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset abandons the instruction: no writes, FETCH-style selects
        if (rst) begin
            state_next = S_FETCH;
            pcWrite    = 1'b0;
            adrSrc     = 1'b0;
            memRead    = 1'b0;
            memWrite   = 1'b0;
            irWrite    = 1'b0;
            regWrite   = 1'b0;
            illegal    = 1'b0;
            resultSrc  = RES_ALURESULT;
            aluSrcA    = SRCA_PC;
            aluSrcB    = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (mem_state && !memReady && (MEM_WAIT_MAX != 0))
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

`ifdef UC_MC_INSTRET_EN
    always_ff @(posedge clk) begin
        if (rst)
            instret <= '0;
        else if ((state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ)
                 || ((state == S_MEMWRITE) && memReady))
            instret <= instret + 32'd1;
    end
`endif

endmodule
